// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered sync/active/coordinate/strobe outputs.
// Define VGA_TIMING_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
  parameter int WIDTH    = 640,
  parameter int H_FPORCH = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BPORCH = 48,
  parameter int HEIGHT   = 480,
  parameter int V_FPORCH = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BPORCH = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int COORD_W  = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk_vga,
  input  logic               reset,
  input  logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = WIDTH + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOTAL = HEIGHT + V_FPORCH + V_SYNC + V_BPORCH;
  localparam int H_ACT0  = H_SYNC + H_BPORCH;
  localparam int H_ACT1  = H_ACT0 + WIDTH;
  localparam int V_ACT0  = V_SYNC + V_BPORCH;
  localparam int V_ACT1  = V_ACT0 + HEIGHT;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic h_wrap, v_wrap, in_act;
  always_comb begin
    h_wrap        = int'(h_cnt_q) == H_TOTAL - 1;
    v_wrap        = int'(v_cnt_q) == V_TOTAL - 1;
    in_act        = int'(h_cnt_q) >= H_ACT0 && int'(h_cnt_q) < H_ACT1 &&
                    int'(v_cnt_q) >= V_ACT0 && int'(v_cnt_q) < V_ACT1;
    h_cnt_d       = !pix_ce ? h_cnt_q : h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d       = !(pix_ce && h_wrap) ? v_cnt_q : v_wrap ? '0 : v_cnt_q + 1'b1;
    hsync_d       = !pix_ce ? hsync_q : int'(h_cnt_q) < H_SYNC ? H_POL : ~H_POL;
    vsync_d       = !pix_ce ? vsync_q : int'(v_cnt_q) < V_SYNC ? V_POL : ~V_POL;
    active_d      = !pix_ce ? active_q : in_act;
    pix_x_d       = !pix_ce ? pix_x_q : in_act ? COORD_W'(int'(h_cnt_q) - H_ACT0) : '0;
    pix_y_d       = !pix_ce ? pix_y_q : in_act ? COORD_W'(int'(v_cnt_q) - V_ACT0) : '0;
    // strobes are single clk_vga pulses, never held across disabled clocks
    line_start_d  = pix_ce && h_cnt_q == '0;
    frame_start_d = line_start_d && v_cnt_q == '0;
  end
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;
  always_comb frame_count_d = (pix_ce && h_wrap && v_wrap) ? frame_count_q + 1'b1 : frame_count_q;
  always_ff @(posedge clk_vga) begin
    if (reset) frame_count_q <= '0;
    else frame_count_q <= frame_count_d;
  end
  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default 640x480 instance and a tiny
// active-high instance (8x6 total) used for frame wrap and frame counter coverage.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif
  logic clk_vga = 1'b0;
  logic rst_a = 1'b1, ce_a = 1'b1, rst_b = 1'b1, ce_b = 1'b1;
  logic hs_a, vs_a, act_a, ls_a, fs_a;
  logic [9:0] px_a, py_a;
  logic [7:0] fc_a;
  logic hs_b, vs_b, act_b, ls_b, fs_b;
  logic [3:0] px_b, py_b;
  logic [1:0] fc_b;
  int total = 0, bad = 0, pos_a = 0, pos_b = 0;
  always #5 clk_vga = ~clk_vga;
  vga_timing_gen dut_a (
    .clk_vga(clk_vga), .reset(rst_a), .pix_ce(ce_a), .hsync(hs_a), .vsync(vs_a),
    .active(act_a), .pix_x(px_a), .pix_y(py_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );
  vga_timing_gen #(
    .WIDTH(4), .H_FPORCH(1), .H_SYNC(2), .H_BPORCH(1),
    .HEIGHT(3), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
    .H_POL(1'b1), .V_POL(1'b1), .COORD_W(4), .FRAME_W(2)
  ) dut_b (
    .clk_vga(clk_vga), .reset(rst_b), .pix_ce(ce_b), .hsync(hs_b), .vsync(vs_b),
    .active(act_b), .pix_x(px_b), .pix_y(py_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_vga);
    @(negedge clk_vga);
  endtask
  // outputs shown after an enabled edge describe linear position pos (h + v*H_TOTAL)
  task automatic adv_a(input int p);
    while (pos_a < p) begin tick(); pos_a++; end
  endtask
  task automatic adv_b(input int p);
    while (pos_b < p) begin tick(); pos_b++; end
  endtask
  initial begin
    @(negedge clk_vga);
    tick(); tick();
    chk("rst hsync", int'(hs_a), 1);
    chk("rst vsync", int'(vs_a), 1);
    chk("rst active", int'(act_a), 0);
    chk("rst pix_x", int'(px_a), 0);
    chk("rst line_start", int'(ls_a), 0);
    chk("rst frame_start", int'(fs_a), 0);
    chk("rst frame_count", int'(fc_a), 0);
    rst_a = 1'b0;
    tick();
    chk("p00 hsync", int'(hs_a), 0);
    chk("p00 vsync", int'(vs_a), 0);
    chk("p00 active", int'(act_a), 0);
    chk("p00 line_start", int'(ls_a), 1);
    chk("p00 frame_start", int'(fs_a), 1);
    for (int h = 1; h < 800; h++) begin
      tick(); pos_a++;
      chk("sweep hsync", int'(hs_a), h < 96 ? 0 : 1);
      if (h == 1 || h == 799) chk("sweep line_start", int'(ls_a), 0);
    end
    tick(); pos_a++;
    chk("p0_1 line_start", int'(ls_a), 1);
    chk("p0_1 frame_start", int'(fs_a), 0);
    chk("p0_1 vsync", int'(vs_a), 0);
    adv_a(35*800 + 143);
    chk("p143_35 active", int'(act_a), 0);
    chk("p143_35 pix_x", int'(px_a), 0);
    chk("p143_35 vsync", int'(vs_a), 1);
    adv_a(35*800 + 144);
    chk("p144_35 active", int'(act_a), 1);
    chk("p144_35 pix_x", int'(px_a), 0);
    chk("p144_35 pix_y", int'(py_a), 0);
    adv_a(35*800 + 145);
    chk("p145_35 pix_x", int'(px_a), 1);
    adv_a(35*800 + 783);
    chk("p783_35 active", int'(act_a), 1);
    chk("p783_35 pix_x", int'(px_a), 639);
    adv_a(35*800 + 784);
    chk("p784_35 active", int'(act_a), 0);
    chk("p784_35 pix_x", int'(px_a), 0);
    adv_a(35*800 + 799);
    ce_a = 1'b0; tick();
    chk("ce0 hsync hold", int'(hs_a), 1);
    chk("ce0 line_start", int'(ls_a), 0);
    ce_a = 1'b1; tick(); pos_a++;
    chk("ce1 line_start", int'(ls_a), 1);
    chk("ce1 hsync", int'(hs_a), 0);
    ce_a = 1'b0; tick();
    chk("ce0 line_start drop", int'(ls_a), 0);
    chk("ce0 hsync hold2", int'(hs_a), 0);
    chk("ce0 pix_y hold", int'(py_a), 0);
    ce_a = 1'b1; tick(); pos_a++;
    chk("ce1 p1_36 line_start", int'(ls_a), 0);
    adv_a(36*800 + 400);
    chk("p400_36 active", int'(act_a), 1);
    chk("p400_36 pix_x", int'(px_a), 256);
    chk("p400_36 pix_y", int'(py_a), 1);
    rst_a = 1'b1; tick();
    chk("mid rst hsync", int'(hs_a), 1);
    chk("mid rst active", int'(act_a), 0);
    chk("mid rst pix_x", int'(px_a), 0);
    chk("mid rst frame_start", int'(fs_a), 0);
    rst_a = 1'b0; tick();
    chk("after rst frame_start", int'(fs_a), 1);
    chk("after rst hsync", int'(hs_a), 0);
    chk("after rst frame_count", int'(fc_a), 0);
    // small instance: H_TOTAL=8 (sync 0-1, active 3-6), V_TOTAL=6 (sync 0, active 2-4)
    rst_b = 1'b0; tick();
    chk("b p00 hsync", int'(hs_b), 1);
    chk("b p00 vsync", int'(vs_b), 1);
    chk("b p00 frame_start", int'(fs_b), 1);
    adv_b(1);
    chk("b p1 hsync", int'(hs_b), 1);
    adv_b(2);
    chk("b p2 hsync", int'(hs_b), 0);
    adv_b(19);
    chk("b p3_2 active", int'(act_b), 1);
    chk("b p3_2 pix_x", int'(px_b), 0);
    chk("b p3_2 pix_y", int'(py_b), 0);
    adv_b(38);
    chk("b p6_4 pix_x", int'(px_b), 3);
    chk("b p6_4 pix_y", int'(py_b), 2);
    adv_b(39);
    chk("b p7_4 active", int'(act_b), 0);
    adv_b(46);
    chk("b p6_5 frame_count", int'(fc_b), 0);
    adv_b(47);
    chk("b p7_5 frame_count", int'(fc_b), FC_EN ? 1 : 0);
    adv_b(48);
    chk("b wrap frame_start", int'(fs_b), 1);
    chk("b wrap vsync", int'(vs_b), 1);
    adv_b(47 + 2*48);
    chk("b fc 3", int'(fc_b), FC_EN ? 3 : 0);
    adv_b(47 + 3*48);
    chk("b fc modulo", int'(fc_b), 0);
    adv_b(47 + 3*48 + 20);
    rst_b = 1'b1; tick();
    chk("b mid rst hsync", int'(hs_b), 0);
    chk("b mid rst frame_count", int'(fc_b), 0);
    rst_b = 1'b0; tick();
    chk("b after rst frame_start", int'(fs_b), 1);
    chk("b after rst frame_count", int'(fc_b), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
